// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

    // Wide enough for both the latency and the starvation counters (legal max 15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/arb_priority_sel.sv
// Winner select between fetch and data ports, plus the fetch starvation counter update.
module arb_priority_sel
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic             arb_en,
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             if_gnt,
    output logic             d_gnt,
    output logic [CNT_W-1:0] starve_nxt
);

    logic starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        if_gnt     = arb_en && if_req && (!d_req || starved);
        d_gnt      = arb_en && d_req && !if_gnt;
        starve_nxt = starve_cnt;
        if (if_gnt)
            starve_nxt = '0;
        else if (d_gnt && if_req && !starved)
            starve_nxt = starve_cnt + CNT_W'(1);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported word memory between the fetch and data ports.
// All state advances on the falling clock edge to line up with the CPU pipeline.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state, state_nxt;
    logic [CNT_W-1:0]  lat_cnt;
    logic [CNT_W-1:0]  starve_cnt, starve_nxt;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-3:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // Byte-offset bits are dropped: accesses are always whole words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    arb_priority_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
        .arb_en     (state == IDLE),
        .if_req     (if_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt),
        .if_gnt     (if_gnt),
        .d_gnt      (d_gnt),
        .starve_nxt (starve_nxt)
    );

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            case (state)
                IDLE: if (if_gnt || d_gnt) begin
                    owner_q <= d_gnt ? OWN_D : OWN_IF;
                    we_q    <= d_gnt && d_we;
                    addr_q  <= d_gnt ? d_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
                    wdata_q <= d_wdata;
                end
                ISSUE: lat_cnt <= CNT_W'(MEM_LAT - 1);
                WAIT: begin
                    if (lat_cnt != '0)
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    else if (!we_q) begin
                        if (owner_q == OWN_D) d_rdata  <= mem_rdata;
                        else                  if_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        case (state)
            IDLE:  if (if_gnt || d_gnt) state_nxt = ISSUE;
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                state_nxt = WAIT;
            end
            WAIT:  if (lat_cnt == '0) state_nxt = RESP;
            RESP: begin
                if_rvalid = (owner_q == OWN_IF);
                d_rvalid  = (owner_q == OWN_D);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: per-cycle vector table plus hand sequences for starvation, reset and MEM_LAT=1.
module tb_mem_port_arbiter;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic        clock = 1'b0;
    logic        reset_n;
    always #5 clock = ~clock;

    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [29:0] mem_addr;

    logic        m1_if_req, m1_d_req, m1_d_we;
    logic [31:0] m1_if_addr, m1_d_addr, m1_d_wdata;
    logic        m1_if_gnt, m1_if_rvalid, m1_d_gnt, m1_d_rvalid, m1_mem_en, m1_mem_we;
    logic [31:0] m1_if_rdata, m1_d_rdata, m1_mem_wdata, m1_mem_rdata;
    logic [29:0] m1_mem_addr;

    mem_port_arbiter #(.MEM_LAT(LAT0), .STARVE_MAX(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(LAT1), .STARVE_MAX(2)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .if_req(m1_if_req), .if_addr(m1_if_addr), .if_gnt(m1_if_gnt), .if_rvalid(m1_if_rvalid), .if_rdata(m1_if_rdata),
        .d_req(m1_d_req), .d_we(m1_d_we), .d_addr(m1_d_addr), .d_wdata(m1_d_wdata),
        .d_gnt(m1_d_gnt), .d_rvalid(m1_d_rvalid), .d_rdata(m1_d_rdata),
        .mem_en(m1_mem_en), .mem_we(m1_mem_we), .mem_addr(m1_mem_addr), .mem_wdata(m1_mem_wdata), .mem_rdata(m1_mem_rdata)
    );

    // Memory models: read data is only valid in the last latency cycle, garbage otherwise.
    logic [31:0] mem0 [16];
    logic [31:0] rd0;
    logic [3:0]  cnt0;
    logic        pend0;
    always @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mem0[i] <= 32'd0;
            mem0[0] <= 32'd5;
            mem0[1] <= 32'd7;
            rd0 <= 32'd0; cnt0 <= 4'd0; pend0 <= 1'b0;
        end else begin
            if (mem_en && mem_we) mem0[mem_addr[3:0]] <= mem_wdata;
            if (mem_en && !mem_we) begin
                rd0 <= mem0[mem_addr[3:0]]; cnt0 <= 4'(LAT0 - 1); pend0 <= 1'b1;
            end else if (pend0) begin
                if (cnt0 == 4'd0) pend0 <= 1'b0;
                else cnt0 <= cnt0 - 4'd1;
            end
        end
    end
    assign mem_rdata = (pend0 && cnt0 == 4'd0) ? rd0 : 32'hDEAD_BEEF;

    logic [31:0] mem1 [16];
    logic [31:0] rd1;
    logic [3:0]  cnt1;
    logic        pend1;
    always @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mem1[i] <= 32'd0;
            mem1[0] <= 32'd5;
            mem1[1] <= 32'd7;
            rd1 <= 32'd0; cnt1 <= 4'd0; pend1 <= 1'b0;
        end else begin
            if (m1_mem_en && m1_mem_we) mem1[m1_mem_addr[3:0]] <= m1_mem_wdata;
            if (m1_mem_en && !m1_mem_we) begin
                rd1 <= mem1[m1_mem_addr[3:0]]; cnt1 <= 4'(LAT1 - 1); pend1 <= 1'b1;
            end else if (pend1) begin
                if (cnt1 == 4'd0) pend1 <= 1'b0;
                else cnt1 <= cnt1 - 4'd1;
            end
        end
    end
    assign m1_mem_rdata = (pend1 && cnt1 == 4'd0) ? rd1 : 32'hDEAD_BEEF;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr, dw;
        logic [31:0] da, dwd;
        logic        ig, dg, en, we;
        logic [29:0] ma;
        logic        irv, drv;
        logic [31:0] ird, drd;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t v(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] dwd,
                               input logic ig, input logic dg, input logic en, input logic we,
                               input logic [29:0] ma, input logic irv, input logic drv,
                               input logic [31:0] ird, input logic [31:0] drd);
        vec_t r;
        r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw; r.da = da; r.dwd = dwd;
        r.ig = ig; r.dg = dg; r.en = en; r.we = we; r.ma = ma;
        r.irv = irv; r.drv = drv; r.ird = ird; r.drd = drd;
        return r;
    endfunction

    vec_t vt [27];
    logic [99:0] got_b, exp_b;
    logic        exp_d [6];
    int ng, last_g, lat, nrv, g0, g1, rv1;
    logic post;

    initial begin
        //      ir ia   dr dw da     dwd    ig dg en we ma  irv drv ird drd
        vt[0]  = v(0, 0,  0, 0, 0,     0,     0, 0, 0, 0, 0,  0, 0, 0, 0);
        vt[1]  = v(1, 4,  0, 0, 0,     0,     1, 0, 0, 0, 0,  0, 0, 0, 0);
        vt[2]  = v(0, 0,  0, 0, 0,     0,     0, 0, 1, 0, 1,  0, 0, 0, 0);
        vt[3]  = v(0, 0,  1, 0, 0,     0,     0, 0, 0, 0, 0,  0, 0, 0, 0);
        vt[4]  = v(0, 0,  0, 0, 0,     0,     0, 0, 0, 0, 0,  0, 0, 0, 0);
        vt[5]  = v(0, 0,  0, 0, 0,     0,     0, 0, 0, 0, 0,  1, 0, 7, 0);
        vt[6]  = v(1, 4,  1, 0, 0,     0,     0, 1, 0, 0, 0,  0, 0, 7, 0);
        vt[7]  = v(1, 4,  0, 0, 0,     0,     0, 0, 1, 0, 0,  0, 0, 7, 0);
        vt[8]  = v(1, 4,  0, 0, 0,     0,     0, 0, 0, 0, 0,  0, 0, 7, 0);
        vt[9]  = v(1, 4,  0, 0, 0,     0,     0, 0, 0, 0, 0,  0, 0, 7, 0);
        vt[10] = v(1, 4,  0, 0, 0,     0,     0, 0, 0, 0, 0,  0, 1, 7, 5);
        vt[11] = v(1, 4,  0, 0, 0,     0,     1, 0, 0, 0, 0,  0, 0, 7, 5);
        vt[12] = v(0, 0,  0, 0, 0,     0,     0, 0, 1, 0, 1,  0, 0, 7, 5);
        vt[13] = v(0, 0,  0, 0, 0,     0,     0, 0, 0, 0, 0,  0, 0, 7, 5);
        vt[14] = v(0, 0,  0, 0, 0,     0,     0, 0, 0, 0, 0,  0, 0, 7, 5);
        vt[15] = v(0, 0,  0, 0, 0,     0,     0, 0, 0, 0, 0,  1, 0, 7, 5);
        vt[16] = v(0, 0,  1, 1, 8,     'h2A,  0, 1, 0, 0, 0,  0, 0, 7, 5);
        vt[17] = v(0, 0,  0, 1, 8,     'h2A,  0, 0, 1, 1, 2,  0, 0, 7, 5);
        vt[18] = v(0, 0,  0, 0, 0,     0,     0, 0, 0, 0, 0,  0, 0, 7, 5);
        vt[19] = v(0, 0,  0, 0, 0,     0,     0, 0, 0, 0, 0,  0, 0, 7, 5);
        vt[20] = v(0, 0,  0, 0, 0,     0,     0, 0, 0, 0, 0,  0, 1, 7, 5);
        vt[21] = v(0, 0,  1, 0, 'hB,   0,     0, 1, 0, 0, 0,  0, 0, 7, 5);
        vt[22] = v(0, 0,  0, 0, 0,     0,     0, 0, 1, 0, 2,  0, 0, 7, 5);
        vt[23] = v(0, 0,  0, 0, 0,     0,     0, 0, 0, 0, 0,  0, 0, 7, 5);
        vt[24] = v(0, 0,  0, 0, 0,     0,     0, 0, 0, 0, 0,  0, 0, 7, 5);
        vt[25] = v(0, 0,  0, 0, 0,     0,     0, 0, 0, 0, 0,  0, 1, 7, 'h2A);
        vt[26] = v(0, 0,  0, 0, 0,     0,     0, 0, 0, 0, 0,  0, 0, 7, 'h2A);
        exp_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        reset_n = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        m1_if_req = 0; m1_if_addr = 0; m1_d_req = 0; m1_d_we = 0; m1_d_addr = 0; m1_d_wdata = 0;
        repeat (2) @(negedge clock);
        @(posedge clock) reset_n = 1'b1;
        @(negedge clock); #1;

        // Cycle-by-cycle vectors: reset state, fetch, contention, write, read-back.
        for (int i = 0; i < 27; i++) begin
            if_req = vt[i].ir; if_addr = vt[i].ia;
            d_req = vt[i].dr; d_we = vt[i].dw; d_addr = vt[i].da; d_wdata = vt[i].dwd;
            @(posedge clock);
            got_b = {if_gnt, d_gnt, mem_en, mem_we, vt[i].en ? mem_addr : 30'd0,
                     if_rvalid, d_rvalid, if_rdata, d_rdata};
            exp_b = {vt[i].ig, vt[i].dg, vt[i].en, vt[i].we, vt[i].ma,
                     vt[i].irv, vt[i].drv, vt[i].ird, vt[i].drd};
            check($sformatf("vec%0d", i), 128'(got_b), 128'(exp_b));
            @(negedge clock); #1;
        end

        // Both ports hold requests: expect d,d,if,d,d,if every MEM_LAT+3 cycles.
        if_req = 1; if_addr = 4; d_req = 1; d_we = 0; d_addr = 0;
        ng = 0; last_g = 0; post = 0;
        for (int cyc = 0; cyc < 40 && ng < 6; cyc++) begin
            @(posedge clock);
            if (if_gnt || d_gnt) begin
                check($sformatf("grant%0d_is_d", ng), 128'(d_gnt), 128'(exp_d[ng]));
                if (if_gnt) check($sformatf("starve_before_if%0d", ng), 128'(dut.starve_cnt), 128'd2);
                if (ng > 0) check($sformatf("grant%0d_spacing", ng), 128'(cyc - last_g), 128'd5);
                last_g = cyc;
                post = if_gnt;
                ng++;
            end
            @(negedge clock); #1;
            if (post) begin
                check("starve_after_if", 128'(dut.starve_cnt), 128'd0);
                post = 0;
            end
        end
        check("grant_count", 128'(ng), 128'd6);
        if_req = 0; d_req = 0;
        repeat (6) @(negedge clock);
        #1;

        // Reset during WAIT abandons the fetch.
        if_req = 1; if_addr = 4;
        @(posedge clock);
        check("rst_pre_gnt", 128'(if_gnt), 128'd1);
        @(negedge clock); #1; if_req = 0;
        @(negedge clock); #1;
        @(posedge clock); reset_n = 1'b0; #1;
        check("rst_strobes", 128'({mem_en, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid}), 128'd0);
        check("rst_rdata", 128'({if_rdata, d_rdata}), 128'd0);
        @(negedge clock);
        @(posedge clock); reset_n = 1'b1;
        nrv = 0;
        repeat (6) begin
            @(posedge clock);
            if (if_rvalid || d_rvalid) nrv++;
        end
        check("rst_no_rvalid", 128'(nrv), 128'd0);
        @(negedge clock); #1;
        if_req = 1; if_addr = 0;
        @(posedge clock);
        check("post_rst_gnt", 128'(if_gnt), 128'd1);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock); #1; if_req = 0;
            @(posedge clock);
            if (if_rvalid) begin lat = k; break; end
        end
        check("post_rst_latency", 128'(lat), 128'd4);
        check("post_rst_rdata", 128'(if_rdata), 128'd5);
        @(negedge clock); #1;

        // MEM_LAT=1 instance with fetch held high.
        m1_if_req = 1; m1_if_addr = 0;
        g0 = -1; g1 = -1; rv1 = -1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clock);
            if (m1_if_gnt) begin
                if (g0 < 0) g0 = cyc;
                else if (g1 < 0) g1 = cyc;
            end
            if (m1_if_rvalid && rv1 < 0) begin
                rv1 = cyc;
                check("m1_rdata", 128'(m1_if_rdata), 128'd5);
            end
            @(negedge clock); #1;
        end
        m1_if_req = 0;
        check("m1_latency", 128'(rv1 - g0), 128'd3);
        check("m1_spacing", 128'(g1 - g0), 128'd4);
        check("m1_first_gnt_seen", 128'(g0 >= 0), 128'd1);
        check("m1_d_idle", 128'({m1_d_gnt, m1_d_rvalid, m1_d_rdata}), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
